// File: rtl/seed_chain_reader.sv
// Walks the expanded-seed memory in index order, runs each seed through
// chain_len iterations of the keyed F hash on a shared sha256 core, and streams the chain ends.
module seed_chain_reader #(
  parameter int                 KEY_LEN             = 256,
  parameter int                 SEED_NUM            = 40,
  parameter logic [KEY_LEN-1:0] XMSS_HASH_PADDING_F = '0,
  parameter int                 CHAIN_W             = 4,
  localparam int                IDX_W               = (SEED_NUM > 1) ? $clog2(SEED_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_LEN-1:0]   input_key,
  input  logic [CHAIN_W-1:0]   chain_len,
  output logic                 busy,
  output logic                 done,
  output logic                 hash_start,
  output logic [4*KEY_LEN-1:0] hash_data_in,
  output logic                 message_length,
  input  logic                 hash_done,
  input  logic [KEY_LEN-1:0]   hash_data_out,
  output logic [IDX_W-1:0]     seed_mem_rd_addr,
  output logic                 seed_mem_rd_en,
  input  logic [KEY_LEN-1:0]   seed_rd_data,
  output logic [KEY_LEN-1:0]   result_data,
  output logic [IDX_W-1:0]     result_idx,
  output logic                 result_valid
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    LOAD      = 3'd2,
    HASH_WAIT = 3'd3,
    EMIT      = 3'd4,
    FIN       = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEED_NUM - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CHAIN_W-1:0]   step_q, step_d;
  logic [CHAIN_W-1:0]   len_q, len_d;
  logic [KEY_LEN-1:0]   chain_q, chain_d;
  logic [KEY_LEN-1:0]   res_data_q, res_data_d;
  logic [IDX_W-1:0]     res_idx_q, res_idx_d;
  logic                 res_valid_q, res_valid_d;
  logic                 hash_start_q, hash_start_d;
  logic                 rd_en_q, rd_en_d;
  logic                 done_q, done_d;
  logic [CHAIN_W-1:0]   step_inc;
  logic                 last_hash;

  assign step_inc  = step_q + CHAIN_W'(1);
  assign last_hash = (step_inc == len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = READ;
      READ:      state_d = LOAD;
      LOAD:      state_d = (len_q == '0) ? EMIT : HASH_WAIT;
      HASH_WAIT: if (hash_done && last_hash) state_d = EMIT;
      EMIT:      state_d = (idx_q == LAST_IDX) ? FIN : READ;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered outputs are derived from the upcoming state so each pulse lines up with its state.
  always_comb begin
    idx_d        = idx_q;
    step_d       = step_q;
    len_d        = len_q;
    chain_d      = chain_q;
    res_data_d   = res_data_q;
    res_idx_d    = res_idx_q;
    rd_en_d      = (state_d == READ);
    res_valid_d  = (state_d == EMIT);
    done_d       = (state_d == FIN);
    hash_start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d = '0;
          len_d = chain_len;
        end
      end
      LOAD: begin
        chain_d = seed_rd_data;
        step_d  = '0;
        if (len_q == '0) begin
          res_data_d = seed_rd_data;
          res_idx_d  = idx_q;
        end else begin
          hash_start_d = 1'b1;
        end
      end
      HASH_WAIT: begin
        if (hash_done) begin
          chain_d = hash_data_out;
          step_d  = step_inc;
          if (last_hash) begin
            res_data_d = hash_data_out;
            res_idx_d  = idx_q;
          end else begin
            hash_start_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      step_q       <= '0;
      len_q        <= '0;
      chain_q      <= '0;
      res_data_q   <= '0;
      res_idx_q    <= '0;
      res_valid_q  <= 1'b0;
      hash_start_q <= 1'b0;
      rd_en_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      step_q       <= step_d;
      len_q        <= len_d;
      chain_q      <= chain_d;
      res_data_q   <= res_data_d;
      res_idx_q    <= res_idx_d;
      res_valid_q  <= res_valid_d;
      hash_start_q <= hash_start_d;
      rd_en_q      <= rd_en_d;
      done_q       <= done_d;
    end
  end

  // FIN counts as idle for busy so busy falls in the same cycle done pulses.
  assign busy             = start | ((state_q != IDLE) && (state_q != FIN));
  assign done             = done_q;
  assign hash_start       = hash_start_q;
  assign hash_data_in     = {XMSS_HASH_PADDING_F, input_key, chain_q, {KEY_LEN{1'b0}}};
  assign message_length   = 1'b0;
  assign seed_mem_rd_addr = idx_q;
  assign seed_mem_rd_en   = rd_en_q;
  assign result_data      = res_data_q;
  assign result_idx       = res_idx_q;
  assign result_valid     = res_valid_q;

endmodule
